muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- RV32M execute unit in the EX stage, alongside the integer ALU.
- Executes MUL/MULH/MULHSU/MULHU in one cycle.
- Executes DIV/DIVU/REM/REMU with a 32-step restoring divider.
- The hazard unit stalls IF/ID/EX while busy=1. result/rd_out feed the alu_result and rd inputs of the EX/MEM pipeline register on the done cycle.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow complete in 1 cycle. When 0 they take the full divide latency with identical results.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset (0 = reset asserted)
- start  in  1  issue request; sampled only in IDLE or DONE
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_val  in  XLEN  operand A (dividend)
- rs2_val  in  XLEN  operand B (divisor)
- rd_in  in  5  destination register tag
- flush  in  1  synchronous kill (branch/jump redirect)
- busy  out  1  high while a divide is iterating
- done  out  1  one-cycle pulse; result and rd_out valid
- result  out  XLEN  operation result
- rd_out  out  5  tag captured at start

Behaviour:
Reset
- reset=0 asynchronously forces state=IDLE and clears busy, done, result, rd_out, counter and internal registers.
- Release is synchronous to clk.
- Reset mid-divide abandons the operation; no done is produced.

States
- IDLE, DIV_RUN, DONE.
- busy = (state==DIV_RUN). done = (state==DONE).

Start acceptance
- start is accepted in IDLE or DONE at the clock edge; start in DIV_RUN is ignored.
- On acceptance, funct3, operands and rd_in are captured.
- Call the cycle start is asserted "cycle 0".

Multiply (funct3 0-3)
- Full 64-bit product computed from captured operands and registered.
- Next state DONE; done=1 in cycle 1.
- MUL returns product[31:0].
- MULH: signed x signed, returns [63:32].
- MULHSU: signed rs1 x unsigned rs2, returns [63:32].
- MULHU: unsigned x unsigned, returns [63:32].

Divide (funct3 4-7), normal path
- Signed ops take magnitudes.
- Counter loads 31; state DIV_RUN in cycles 1..32, one quotient bit per cycle MSB-first, counter decrements.
- When counter==0, next state DONE; done=1 in cycle 33.
- Signed quotient is negated if operand signs differ. Signed remainder takes the dividend's sign.

Divide special cases (results mandatory)
- Divisor 0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = rs1_val.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, REM 0.
- EARLY_OUT=1: these go straight to DONE (done in cycle 1).

DONE
- Lasts exactly one cycle. Next state is IDLE, or a new operation if start=1 (back-to-back issue, no bubble).
- result and rd_out hold their value after done until the next completion.

flush
- Forces state=IDLE at the next edge from any state and suppresses a pending done.
- Overrides a simultaneous start.
- result/rd_out are not cleared.

Test Plan:
- Reset asserted mid-DIV_RUN (cycle 10) -> busy, done, result, rd_out = 0 immediately without a clock edge; after release, unit idle and accepts start.
- MUL 7 x 0xFFFFFFFD, rd_in=5 -> done in cycle 1, result=0xFFFFFFEB, rd_out=5. Then MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> busy cycles 1-32, done cycle 33, result=0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
- DIVU 123/0 -> 0xFFFFFFFF in cycle 1. REM 123/0 -> 123. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. With EARLY_OUT=0, same values in cycle 33.
- DIV started; flush in cycle 10 -> IDLE at next edge, busy=0, no done pulse ever. flush+start in the same cycle -> start dropped.
- MUL completing (DONE) with start=1 for DIVU 9/3 in the same cycle -> DIVU done 33 cycles later, result=3. start during DIV_RUN is ignored with no effect.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M execute unit sitting beside the integer ALU in EX.
//
// Multiplies (MUL/MULH/MULHSU/MULHU) complete one cycle after issue.
// Divides (DIV/DIVU/REM/REMU) run a 32-step restoring divider. With
// EARLY_OUT=1, divide-by-zero and signed overflow finish in one cycle.
// With EARLY_OUT=0 they take the full iteration and give the same results.
//
// Handshake: start is a request that is accepted on a rising edge only
// while the unit is in IDLE or DONE and flush is low. done is a one-cycle
// pulse that marks result/rd_out valid. There is no backpressure. The
// pipeline stalls on busy and consumes the result on the done cycle.
// result/rd_out hold their values until the next completion.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      issue request
//   funct3     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rs1_val    operand A / dividend
//   rs2_val    operand B / divisor
//   rd_in      destination register tag
//   flush      synchronous kill; overrides start, suppresses pending done
//   busy       high while a divide is iterating
//   done       one-cycle completion pulse
//   result     operation result
//   rd_out     tag of the completed operation
//   state_dbg  current FSM state (0 IDLE, 1 DIV_RUN, 2 DONE)
//
// Only XLEN=32 is supported because the iteration counter is 5 bits wide.

module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t state, state_next;

    // Divider state
    logic [XLEN-1:0] rem_q;     // partial remainder
    logic [XLEN-1:0] quo_q;     // dividend shifts out the top, quotient bits shift in
    logic [XLEN-1:0] dvs_q;     // divisor magnitude
    logic [4:0]      counter_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            rem_op_q;
    logic [4:0]      rd_q;

    // Issue decode
    logic accept;
    logic is_div;
    assign accept = start && !flush && (state == S_IDLE || state == S_DONE);
    assign is_div = funct3[2];

    // Multiplier: sign- or zero-extend each operand by one bit, then take a
    // single signed product. This covers all four multiply flavours.
    logic                     mul_a_signed;
    logic                     mul_b_signed;
    logic signed [XLEN:0]     mul_a_ext;
    logic signed [XLEN:0]     mul_b_ext;
    logic signed [2*XLEN+1:0] mul_full;
    logic [XLEN-1:0]          mul_res;

    assign mul_a_signed = (funct3 == 3'd1) || (funct3 == 3'd2);
    assign mul_b_signed = (funct3 == 3'd1);
    assign mul_a_ext    = {mul_a_signed & rs1_val[XLEN-1], rs1_val};
    assign mul_b_ext    = {mul_b_signed & rs2_val[XLEN-1], rs2_val};
    assign mul_full     = mul_a_ext * mul_b_ext;
    assign mul_res      = (funct3[1:0] == 2'd0) ? mul_full[XLEN-1:0]
                                                : mul_full[2*XLEN-1:XLEN];

    // Divide setup: operate on magnitudes and remember the sign fix-ups
    logic            div_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            early_hit;
    logic [XLEN-1:0] early_res;

    assign div_signed = ~funct3[0];
    assign a_neg      = div_signed & rs1_val[XLEN-1];
    assign b_neg      = div_signed & rs2_val[XLEN-1];
    assign a_mag      = a_neg ? -rs1_val : rs1_val;
    assign b_mag      = b_neg ? -rs2_val : rs2_val;
    assign div_zero   = (rs2_val == '0);
    assign div_ovf    = div_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                        && (rs2_val == '1);
    assign early_hit  = EARLY_OUT && is_div && (div_zero || div_ovf);
    // On overflow the quotient equals the dividend (most negative value)
    assign early_res  = funct3[1] ? (div_zero ? rs1_val : '0)
                                  : (div_zero ? '1 : rs1_val);

    // One restoring step. The shifted remainder can need XLEN+1 bits.
    // A remainder that fits always stays below the divisor, so XLEN bits
    // are enough to store it.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            rem_ge;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;
    logic [XLEN-1:0] div_res;

    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign rem_ge   = (shifted >= {1'b0, dvs_q});
    assign rem_next = rem_ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_next = {quo_q[XLEN-2:0], rem_ge};
    assign quo_fin  = neg_quo_q ? -quo_next : quo_next;
    assign rem_fin  = neg_rem_q ? -rem_next : rem_next;
    assign div_res  = rem_op_q ? rem_fin : quo_fin;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                state_next = S_IDLE;
                if (accept) begin
                    state_next = (is_div && !early_hit) ? S_DIV_RUN : S_DONE;
                end
            end
            S_DIV_RUN: begin
                if (counter_q == 5'd0) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            counter_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_op_q  <= 1'b0;
            rd_q      <= '0;
            result    <= '0;
            rd_out    <= '0;
        end else if (accept) begin
            rd_q      <= rd_in;
            rem_op_q  <= funct3[1];
            // A zero divisor must yield all-ones for signed DIV too, so the
            // quotient is never negated in that case.
            neg_quo_q <= (a_neg ^ b_neg) & ~div_zero;
            neg_rem_q <= a_neg;
            dvs_q     <= b_mag;
            quo_q     <= a_mag;
            rem_q     <= '0;
            counter_q <= 5'd31;
            if (!is_div) begin
                result <= mul_res;
                rd_out <= rd_in;
            end else if (early_hit) begin
                result <= early_res;
                rd_out <= rd_in;
            end
        end else if (state == S_DIV_RUN && !flush) begin
            rem_q     <= rem_next;
            quo_q     <= quo_next;
            counter_q <= counter_q - 5'd1;
            if (counter_q == 5'd0) begin
                result <= div_res;
                rd_out <= rd_q;
            end
        end
    end

    assign busy      = (state == S_DIV_RUN);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// dut uses EARLY_OUT=1 and dut0 uses EARLY_OUT=0. The two instances share
// operands, flush and reset, and each has its own start.
// Each scoreboard entry is {done cycle, rd, result} and is popped when done
// is seen. Cycle n counts rising edges after the issue cycle.

module tb_muldiv_unit;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        start0 = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_in = '0;

    logic        busy, done, busy0, done0;
    logic [31:0] result, result0;
    logic [4:0]  rd_out, rd_out0;
    logic [1:0]  state_dbg, state_dbg0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [68:0] exp_q[$];
    logic [68:0] exp0_q[$];
    logic [68:0] ent_m, ent0_m;

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk(clk), .reset(rst_n), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out),
        .state_dbg(state_dbg)
    );

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut0 (
        .clk(clk), .reset(rst_n), .start(start0), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
        .busy(busy0), .done(done0), .result(result0), .rd_out(rd_out0),
        .state_dbg(state_dbg0)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      pa, pb;
        logic [63:0] p;
        int          sa, sb, r;
        sa = a;
        sb = b;
        case (f)
            F_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            F_MULH:   begin pa = longint'(sa); pb = longint'(sb); p = pa * pb; return p[63:32]; end
            F_MULHSU: begin pa = longint'(sa); pb = longint'({32'b0, b}); p = pa * pb; return p[63:32]; end
            F_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            F_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = sa / sb;
                return r;
            end
            F_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            F_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = sa % sb;
                return r;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && (b == 32'd0 ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    // Scoreboard monitors
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                ent_m = exp_q.pop_front();
                check("result", result, ent_m[31:0]);
                check("rd_out", 32'(rd_out), 32'(ent_m[36:32]));
                check("done_cycle", 32'(cyc), ent_m[68:37]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done0) begin
            if (exp0_q.size() == 0) begin
                check("dut0_unexpected_done", 32'(done0), 32'd0);
            end else begin
                ent0_m = exp0_q.pop_front();
                check("dut0_result", result0, ent0_m[31:0]);
                check("dut0_rd_out", 32'(rd_out0), 32'(ent0_m[36:32]));
                check("dut0_done_cycle", 32'(cyc), ent0_m[68:37]);
            end
        end
    end

    // Driver tasks. issue is called at a falling edge and returns at the
    // falling edge of cycle 1.
    task automatic issue(input bit to0, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int lat, input bit expect_done);
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        if (to0) start0 = 1'b1;
        else     start  = 1'b1;
        if (expect_done) begin
            if (to0) exp0_q.push_back({32'(cyc + lat), rd, exp_res});
            else     exp_q.push_back({32'(cyc + lat), rd, exp_res});
        end
        @(negedge clk);
        start  = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic drain(input bit to0);
        int n;
        n = 0;
        while ((to0 ? (exp0_q.size() != 0 || busy0 == 1'b1)
                    : (exp_q.size() != 0 || busy == 1'b1)) && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 80), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int          cnt;
        logic [2:0]  f;
        logic [31:0] a, b;
        bit          to0;

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiplies
        issue(0, F_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1, 1); drain(0);
        issue(0, F_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 1, 1); drain(0);
        issue(0, F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 1, 1); drain(0);
        issue(0, F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, 1, 1); drain(0);

        // Normal divide with busy window
        issue(0, F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33, 1);
        cnt = int'(busy);
        repeat (32) begin
            @(negedge clk);
            cnt += int'(busy);
        end
        check("busy_cycles", 32'(cnt), 32'd32);
        drain(0);
        issue(0, F_REM,  32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33, 1); drain(0);
        issue(0, F_DIVU, 32'd100,       32'd7, 5'd12, 32'd14,        33, 1); drain(0);
        issue(0, F_REMU, 32'd100,       32'd7, 5'd13, 32'd2,         33, 1); drain(0);

        // Special cases, early out
        issue(0, F_DIVU, 32'd123,       32'd0,         5'd14, 32'hFFFF_FFFF, 1, 1); drain(0);
        issue(0, F_REM,  32'd123,       32'd0,         5'd15, 32'd123,       1, 1); drain(0);
        issue(0, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, 1); drain(0);
        issue(0, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1, 1); drain(0);
        issue(0, F_DIV,  32'hFFFF_FFFB, 32'd0,         5'd18, 32'hFFFF_FFFF, 1, 1); drain(0);

        // Special cases, full latency
        issue(1, F_DIVU, 32'd123,       32'd0,         5'd14, 32'hFFFF_FFFF, 33, 1); drain(1);
        issue(1, F_REM,  32'd123,       32'd0,         5'd15, 32'd123,       33, 1); drain(1);
        issue(1, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 33, 1); drain(1);
        issue(1, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         33, 1); drain(1);
        issue(1, F_DIV,  32'hFFFF_FFFB, 32'd0,         5'd18, 32'hFFFF_FFFF, 33, 1); drain(1);

        // Asynchronous reset in cycle 10 of a divide
        issue(0, F_DIV, 32'd1000, 32'd3, 5'd20, 32'd333, 33, 1);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_state", 32'(state_dbg), 32'd0);
        issue(0, F_MUL, 32'd3, 32'd4, 5'd9, 32'd12, 1, 1); drain(0);

        // Flush in cycle 10 of a divide, no done must follow
        issue(0, F_DIV, 32'd50, 32'd5, 5'd3, 32'd10, 33, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_state", 32'(state_dbg), 32'd0);
        repeat (35) @(negedge clk);
        check("flush_result_kept", result, 32'd12);
        check("flush_rd_kept", 32'(rd_out), 32'd9);

        // Flush together with start drops the start
        flush = 1'b1;
        issue(0, F_MUL, 32'd2, 32'd3, 5'd4, 32'd6, 1, 0);
        flush = 1'b0;
        check("flush_start_state", 32'(state_dbg), 32'd0);
        check("flush_start_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("flush_start_result", result, 32'd12);

        // Back-to-back issue from DONE, then ignored start during DIV_RUN
        issue(0, F_MUL,  32'd6, 32'd7, 5'd1, 32'd42, 1, 1);
        issue(0, F_DIVU, 32'd9, 32'd3, 5'd2, 32'd3, 33, 1);
        repeat (5) @(negedge clk);
        issue(0, F_MUL, 32'd1, 32'd1, 5'd30, 32'd1, 1, 0);
        drain(0);
        repeat (3) @(negedge clk);

        // Random operations against the model
        for (int i = 0; i < 24; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = pick_val();
            b   = pick_val();
            to0 = (i % 3 == 0);
            if (to0)
                issue(1, f, a, b, 5'(i), model(f, a, b), f[2] ? 33 : 1, 1);
            else
                issue(0, f, a, b, 5'(i), model(f, a, b),
                      (f[2] && !is_special(f, a, b)) ? 33 : 1, 1);
            drain(to0);
        end

        check("queues_empty", 32'(exp_q.size() + exp0_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
